// File: rtl/multiplicador_sequencial_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// state encoding, operand width and number of add-and-shift steps.
package multiplicador_sequencial_pkg;

    localparam int WIDTH = 8;
    localparam int STEPS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiplicador_sequencial_adder.sv
// 8-bit ripple-carry adder: one half adder followed by seven full adders.
// The 9-bit sum carries the final carry-out in its top bit.
module multiplicador_sequencial_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [8:0] s
);

    logic [7:0] c;

    assign s[0] = a[0] ^ b[0];
    assign c[0] = a[0] & b[0];

    for (genvar i = 1; i < 8; i++) begin : g_fa
        assign s[i] = a[i] ^ b[i] ^ c[i-1];
        assign c[i] = (a[i] & b[i]) | (c[i-1] & (a[i] ^ b[i]));
    end

    assign s[8] = c[7];

endmodule

// File: rtl/multiplicador_sequencial.sv
// Sequential 8x8 unsigned multiplier, one add-and-shift step per clock.
// Define MULT_ZERO_BYPASS_EN to skip straight to DONE when an operand is zero.
module multiplicador_sequencial #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    import multiplicador_sequencial_pkg::*;

    // Handshake: start is only looked at in IDLE; done is a one-cycle pulse
    // during which p is valid, and p then holds until the next accepted start.
    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH:0]     h_reg;
    logic [3:0]         count;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     h_sel;
    logic [WIDTH:0]     h_shift;
    logic [WIDTH-1:0]   q_shift;
    logic               last_step;
    logic               zero_ops;

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_ops = (a == '0) || (b == '0);
`else
    assign zero_ops = 1'b0;
`endif

    multiplicador_sequencial_adder u_adder (
        .a (h_reg[7:0]),
        .b (m_reg),
        .s (sum)
    );

    // h_reg[8] is always clear at the start of a step (it is shifted down
    // every cycle), so h_reg equals {1'b0, h_reg[7:0]} here.
    assign h_sel     = q_reg[0] ? sum : h_reg;
    assign h_shift   = {1'b0, h_sel[WIDTH:1]};
    assign q_shift   = {h_sel[0], q_reg[WIDTH-1:1]};
    assign last_step = (count == 4'(STEPS - 1));

    assign busy = (state == CALC);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = zero_ops ? DONE : CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            m_reg <= '0;
            q_reg <= '0;
            h_reg <= '0;
            count <= '0;
            p     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= a;
                        q_reg <= b;
                        h_reg <= '0;
                        count <= '0;
                        p     <= '0;
                    end
                end
                CALC: begin
                    h_reg <= h_shift;
                    q_reg <= q_shift;
                    count <= count + 4'd1;
                    if (last_step) p <= {h_shift[WIDTH-1:0], q_shift};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicador_sequencial.sv
// Self-checking bench for multiplicador_sequencial: directed scenarios plus
// randomized operands against a cycle-timed reference model.
module tb_multiplicador_sequencial;

`ifdef MULT_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    // Reference model: cycles elapsed since acceptance (0 = idle).
    int          age = 0;
    int          lat = 9;
    logic [15:0] prod = '0;
    logic [15:0] p_exp = '0;

    multiplicador_sequencial #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            age   = 0;
            p_exp = '0;
        end else if (age == 0) begin
            if (start) begin
                age   = 1;
                lat   = (BYP && (a == 8'd0 || b == 8'd0)) ? 1 : 9;
                prod  = 16'(a) * 16'(b);
                p_exp = '0;
            end
        end else if (age == lat) begin
            age = 0;
        end else begin
            age++;
        end
        if (age != 0 && age == lat) p_exp = prod;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("mon_busy", busy, (age != 0) && (age < lat));
            check_eq("mon_done", done, (age != 0) && (age == lat));
            check_eq("mon_p", p, p_exp);
            check_eq("mon_excl", busy & done, 1'b0);
        end
    end

    task automatic wait_done(input string tag, input int n0, input logic [15:0] pexp, input int lat_exp);
        int n;
        n = n0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 25);
        check_eq({tag, "_lat"}, n, lat_exp);
        check_eq({tag, "_p"}, p, pexp);
    endtask

    task automatic issue_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic [15:0] pexp, input int lat_exp);
        @(posedge clk); #2;
        start = 1'b1; a = av; b = bv;
        @(posedge clk); #2;
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
        wait_done(tag, 0, pexp, lat_exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int dones;
        int idx_q[$];
        logic [7:0] av, bv;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_p", p, 16'h0000);
        @(posedge clk); #2;
        rst = 1'b0;

        issue_op("13x11", 8'd13, 8'd11, 16'h008F, 9);
        issue_op("255x255", 8'd255, 8'd255, 16'hFE01, 9);
        issue_op("0x200", 8'd0, 8'd200, 16'h0000, BYP ? 1 : 9);

        // Second start during CALC must be ignored.
        @(posedge clk); #2;
        start = 1'b1; a = 8'd7; b = 8'd9;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2; start = 1'b1; a = 8'd1; b = 8'd1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done("ign", 4, 16'd63, 9);

        // Reset mid-calculation aborts without a done pulse.
        @(posedge clk); #2;
        start = 1'b1; a = 8'd100; b = 8'd3;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2; rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_p", p, 16'h0000);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("abort_nodone", dones, 0);
        issue_op("2x3", 8'd2, 8'd3, 16'd6, 9);

        // Start held high: back-to-back operations every 10 cycles.
        @(posedge clk); #2;
        start = 1'b1; a = 8'd5; b = 8'd6;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                idx_q.push_back(i);
                check_eq("held_p", p, 16'd30);
            end
        end
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("held_count", idx_q.size(), 3);
        if (idx_q.size() == 3) begin
            check_eq("held_gap1", idx_q[1] - idx_q[0], 10);
            check_eq("held_gap2", idx_q[2] - idx_q[1], 10);
        end

        for (int k = 0; k < 16; k++) begin
            av = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            bv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue_op("rand", av, bv, 16'(av) * 16'(bv),
                     (BYP && (av == 8'd0 || bv == 8'd0)) ? 1 : 9);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
